// File: rtl/idma_arb_pkg.sv
// Shared types and helpers for the iDMA legalizer arbiter.
// The optional priority feature is enabled with IDMA_ARB_PRIO_EN.
package idma_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      HOLD  = 2'd1,
      STALL = 2'd2
   } arb_state_e;

   localparam int unsigned OnehotW = 32;

   // One-hot of id, or zero when id is outside the requester range.
   function automatic logic [OnehotW-1:0] onehot(input int unsigned id, input int unsigned num_req);
      logic [OnehotW-1:0] v;
      if ((id < num_req) && (id < OnehotW)) begin
         v = {{(OnehotW-1){1'b0}}, 1'b1} << id;
      end else begin
         v = {OnehotW{1'b0}};
      end
      return v;
   endfunction

endpackage

// File: rtl/idma_legalizer_id_fifo.sv
// Owner-ID FIFO for in-flight legalizer transfers, plus its protocol checker.
// Exposes the one-hot OR of all live IDs so a kill can report every aborted owner.
module idma_legalizer_id_fifo_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic full,
   input logic empty
);

   // A completion without an outstanding transfer means the legalizer and arbiter disagree.
   a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && empty))
      else $error("id_fifo: pop while empty");

   // The arbiter never issues more transfers than it can track.
   a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
      else $error("id_fifo: push while full");

endmodule

module idma_legalizer_id_fifo
   import idma_arb_pkg::*;
#(
   parameter int unsigned Depth   = 4,
   parameter int unsigned IdWidth = 2,
   parameter int unsigned NumIds  = 4,
   parameter int unsigned CntW    = $clog2(Depth + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [IdWidth-1:0] id_in,
   input  logic               pop,
   output logic               full,
   output logic               empty,
   output logic [IdWidth-1:0] head,
   output logic [CntW-1:0]    count,
   output logic [NumIds-1:0]  live_mask
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [IdWidth-1:0] mem [Depth];
   logic [PtrW-1:0]    wr_ptr;
   logic [PtrW-1:0]    rd_ptr;
   logic               do_push;
   logic               do_pop;
   logic [PtrW:0]      slot;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      logic [PtrW-1:0] n;
      if (p == PtrW'(Depth - 1)) begin
         n = '0;
      end else begin
         n = p + PtrW'(1);
      end
      return n;
   endfunction

   assign full    = (count == CntW'(Depth));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= id_in;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // OR of one-hot owners over the occupied slots, oldest first.
   always_comb begin
      live_mask = '0;
      slot      = '0;
      for (int k = 0; k < int'(Depth); k++) begin
         slot = {1'b0, rd_ptr} + (PtrW+1)'(k);
         slot = (slot >= (PtrW+1)'(Depth)) ? (slot - (PtrW+1)'(Depth)) : slot;
         live_mask = live_mask |
                     ((CntW'(k) < count) ? NumIds'(onehot(32'(mem[slot[PtrW-1:0]]), NumIds)) : '0);
      end
   end

   idma_legalizer_id_fifo_chk u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: rtl/idma_legalizer_arbiter.sv
// Round-robin arbiter sharing one iDMA legalizer among NumReq request sources.
// Define IDMA_ARB_PRIO_EN to add prio_i: high-priority requesters win round-robin among themselves.
module idma_legalizer_arbiter
   import idma_arb_pkg::*;
#(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter type         idma_req_t     = logic,
   parameter int unsigned IdWidth        = $clog2(NumReq)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  idma_req_t         req_i [NumReq],
   input  logic [NumReq-1:0] valid_i,
`ifdef IDMA_ARB_PRIO_EN
   input  logic [NumReq-1:0] prio_i,
`endif
   output logic [NumReq-1:0] ready_o,
   output idma_req_t         leg_req_o,
   output logic              leg_valid_o,
   input  logic              leg_ready_i,
   input  logic              leg_last_i,
   input  logic              kill_i,
   output logic [NumReq-1:0] done_o,
   output logic [NumReq-1:0] aborted_o,
   output logic              busy_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   arb_state_e         state;
   arb_state_e         state_next;
   logic [IdWidth-1:0] rr;
   logic [IdWidth-1:0] rr_next;
   logic [IdWidth-1:0] leg_id;
   logic [IdWidth-1:0] winner;
   logic [IdWidth:0]   slot;
   logic [IdWidth:0]   winner_inc;
   logic [NumReq-1:0]  cand;
   logic [NumReq-1:0]  done_next;
   logic [NumReq-1:0]  aborted_next;
   logic               found;
   logic               grant;
   logic               may_grant;
   logic               push;
   logic               pop;
   logic               full_after;

   logic               fifo_full;
   logic               fifo_empty;
   logic [IdWidth-1:0] fifo_head;
   logic [CntW-1:0]    fifo_count;
   logic [NumReq-1:0]  fifo_live;

   assign leg_valid_o = (state == HOLD);
   assign busy_o      = leg_valid_o | ~fifo_empty;

   // Grant decision, winner search and next-state logic.
   always_comb begin
      push = leg_valid_o & leg_ready_i & ~kill_i;
      pop  = leg_last_i & ~kill_i;

      if (fifo_full) begin
         full_after = ~pop | push;
      end else begin
         full_after = push & ~pop & (fifo_count == CntW'(MaxOutstanding - 1));
      end

      may_grant = ~kill_i & ~full_after &
                  ((state == ARB) | ((state == HOLD) & leg_ready_i));

`ifdef IDMA_ARB_PRIO_EN
      cand = (|(valid_i & prio_i)) ? (valid_i & prio_i) : valid_i;
`else
      cand = valid_i;
`endif

      found  = 1'b0;
      winner = '0;
      slot   = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         slot = {1'b0, rr} + (IdWidth+1)'(i);
         slot = (slot >= (IdWidth+1)'(NumReq)) ? (slot - (IdWidth+1)'(NumReq)) : slot;
         if (!found && cand[slot[IdWidth-1:0]]) begin
            found  = 1'b1;
            winner = slot[IdWidth-1:0];
         end else begin
            found  = found;
         end
      end

      grant      = may_grant & found;
      ready_o    = grant ? NumReq'(onehot(32'(winner), NumReq)) : '0;
      winner_inc = {1'b0, winner} + (IdWidth+1)'(1);
      rr_next    = (winner_inc == (IdWidth+1)'(NumReq)) ? '0 : winner_inc[IdWidth-1:0];

      done_next    = pop ? NumReq'(onehot(32'(fifo_head), NumReq)) : '0;
      aborted_next = kill_i ? (fifo_live | (leg_valid_o ? NumReq'(onehot(32'(leg_id), NumReq)) : '0))
                            : '0;

      state_next = state;
      if (kill_i) begin
         state_next = ARB;
      end else begin
         case (state)
            ARB: begin
               state_next = grant ? HOLD : ARB;
            end
            HOLD: begin
               if (leg_ready_i) begin
                  state_next = grant ? HOLD : (full_after ? STALL : ARB);
               end else begin
                  state_next = HOLD;
               end
            end
            STALL: begin
               state_next = pop ? ARB : STALL;
            end
            default: begin
               state_next = ARB;
            end
         endcase
      end
   end

   // State, output register, rr pointer and completion/abort pulses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= ARB;
         rr        <= '0;
         leg_id    <= '0;
         leg_req_o <= '0;
         done_o    <= '0;
         aborted_o <= '0;
      end else begin
         state     <= state_next;
         done_o    <= done_next;
         aborted_o <= aborted_next;
         if (grant) begin
            leg_req_o <= req_i[winner];
            leg_id    <= winner;
            rr        <= rr_next;
         end
      end
   end

   idma_legalizer_id_fifo #(
      .Depth   (MaxOutstanding),
      .IdWidth (IdWidth),
      .NumIds  (NumReq),
      .CntW    (CntW)
   ) u_id_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (kill_i),
      .push      (push),
      .id_in     (leg_id),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head),
      .count     (fifo_count),
      .live_mask (fifo_live)
   );

endmodule

// File: tb/tb_idma_legalizer_arbiter.sv
// Directed self-checking bench for idma_legalizer_arbiter (4 requesters, 4 outstanding).
// Build with IDMA_ARB_PRIO_EN to also exercise the priority path.
module tb_idma_legalizer_arbiter;

   typedef logic [31:0] req_t;

   logic       clk = 1'b0;
   logic       rst;
   req_t       req [4];
   logic [3:0] valid;
   logic [3:0] ready;
   req_t       leg_req;
   logic       leg_valid;
   logic       leg_ready;
   logic       leg_last;
   logic       kill;
   logic [3:0] done;
   logic [3:0] aborted;
   logic       busy;
`ifdef IDMA_ARB_PRIO_EN
   logic [3:0] prio;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   idma_legalizer_arbiter #(
      .NumReq         (4),
      .MaxOutstanding (4),
      .idma_req_t     (req_t)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .valid_i     (valid),
`ifdef IDMA_ARB_PRIO_EN
      .prio_i      (prio),
`endif
      .ready_o     (ready),
      .leg_req_o   (leg_req),
      .leg_valid_o (leg_valid),
      .leg_ready_i (leg_ready),
      .leg_last_i  (leg_last),
      .kill_i      (kill),
      .done_o      (done),
      .aborted_o   (aborted),
      .busy_o      (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid     = 4'b0000;
      leg_ready = 1'b0;
      leg_last  = 1'b0;
      kill      = 1'b0;
`ifdef IDMA_ARB_PRIO_EN
      prio      = 4'b0000;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      for (int i = 0; i < 4; i++) req[i] = 32'd0;
      tick();
      tick();
      check("rst_leg_valid", leg_valid, 1'b0);
      check("rst_leg_req", leg_req, 32'd0);
      check("rst_ready", ready, 4'b0000);
      check("rst_done", done, 4'b0000);
      check("rst_aborted", aborted, 4'b0000);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;

      // single requester 2, 64-byte request
      req[2] = 32'd64;
      valid  = 4'b0100;
      #1 check("t1_ready", ready, 4'b0100);
      tick();
      valid = 4'b0000;
      check("t1_leg_valid", leg_valid, 1'b1);
      check("t1_leg_req", leg_req, 32'd64);
      #1 check("t1_no_ready", ready, 4'b0000);
      leg_ready = 1'b1;
      tick();
      leg_ready = 1'b0;
      check("t1_leg_valid_drop", leg_valid, 1'b0);
      check("t1_busy_outstanding", busy, 1'b1);
      leg_last = 1'b1;
      tick();
      leg_last = 1'b0;
      check("t1_done", done, 4'b0100);
      tick();
      check("t1_done_pulse", done, 4'b0000);
      check("t1_busy_idle", busy, 1'b0);

      // all valid, back-to-back round robin with one completion per cycle
      do_reset();
      for (int i = 0; i < 4; i++) req[i] = 32'h100 + 32'(i);
      valid     = 4'b1111;
      leg_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         leg_last = (k >= 2);
         #1 check($sformatf("rr_ready_%0d", k), ready, 4'b0001 << (k % 4));
         if (k >= 1) begin
            check($sformatf("rr_leg_valid_%0d", k), leg_valid, 1'b1);
            check($sformatf("rr_leg_req_%0d", k), leg_req, 32'h100 + 32'((k - 1) % 4));
         end
         if (k >= 3) begin
            check($sformatf("rr_done_%0d", k), done, 4'b0001 << ((k - 3) % 4));
         end
         tick();
      end

      // legalizer back-pressure: held request stays put, nobody granted
      leg_ready = 1'b0;
      leg_last  = 1'b0;
      check("bp_done", done, 4'b0010);
      for (int k = 0; k < 5; k++) begin
         #1 check($sformatf("bp_ready_%0d", k), ready, 4'b0000);
         check($sformatf("bp_leg_valid_%0d", k), leg_valid, 1'b1);
         check($sformatf("bp_leg_req_%0d", k), leg_req, 32'h103);
         tick();
      end

      // fill the ID FIFO (holds 2, then 3,0,1) and stall
      leg_ready = 1'b1;
      #1 check("st_ready_s0", ready, 4'b0001);
      tick();
      #1 check("st_ready_s1", ready, 4'b0010);
      tick();
      #1 check("st_ready_s2", ready, 4'b0000);
      check("st_leg_req_s2", leg_req, 32'h101);
      tick();
      #1 check("st_ready_s3", ready, 4'b0000);
      check("st_leg_valid_s3", leg_valid, 1'b0);
      check("st_busy_s3", busy, 1'b1);
      tick();
      leg_last = 1'b1;
      #1 check("st_ready_s4", ready, 4'b0000);
      tick();
      leg_last = 1'b0;
      check("st_done_oldest", done, 4'b0100);
      #1 check("st_regrant", ready, 4'b0100);
      tick();

      // kill with IDs 1,3 outstanding and 0 held; coincident leg_last ignored
      do_reset();
      valid = 4'b0010;
      #1 check("k_ready_1", ready, 4'b0010);
      tick();
      valid     = 4'b1000;
      leg_ready = 1'b1;
      #1 check("k_ready_3", ready, 4'b1000);
      tick();
      valid = 4'b0001;
      #1 check("k_ready_0", ready, 4'b0001);
      tick();
      leg_ready = 1'b0;
      valid     = 4'b1111;
      kill      = 1'b1;
      leg_last  = 1'b1;
      #1 check("k_no_grant", ready, 4'b0000);
      check("k_busy_before", busy, 1'b1);
      tick();
      kill     = 1'b0;
      leg_last = 1'b0;
      valid    = 4'b0000;
      check("k_aborted", aborted, 4'b1011);
      check("k_no_done", done, 4'b0000);
      check("k_leg_valid", leg_valid, 1'b0);
      check("k_busy_after", busy, 1'b0);
      tick();
      check("k_aborted_pulse", aborted, 4'b0000);
      valid = 4'b1111;
      #1 check("k_rr_kept", ready, 4'b0010);
      tick();
      idle();

`ifdef IDMA_ARB_PRIO_EN
      // high-priority requester 3 wins repeatedly
      do_reset();
      valid     = 4'b1111;
      prio      = 4'b1000;
      leg_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         leg_last = (k >= 2);
         #1 check($sformatf("pr_ready_%0d", k), ready, 4'b1000);
         tick();
      end
      prio     = 4'b0000;
      leg_last = 1'b1;
      #1 check("pr_cleared", ready, 4'b0001);
      tick();
      idle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
